// File: rtl/enet_rx_align.sv
// enet_rx_align: turns per-cycle PHY units into a framed byte stream.
// Strips preamble/SFD, packs LSB-first, marks sof/eof/err for the RX MAC.
module enet_rx_align #(
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mii_select,
  input  logic       rmii_select,
  input  logic [7:0] rxd,
  input  logic       rx_dv,
  input  logic       rx_er,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err
);

  localparam int LW = $clog2(MAX_FRAME_LEN + 2);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode;
  logic          rmii, mii;
  logic [7:0]    w_q, w_d;
  logic [7:0]    sh, shc;
  logic          is_p;
  logic [1:0]    last_cnt;
  logic [1:0]    cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_v_q, hold_v_d;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic          ov_d, os_d, oe_d, oerr_d;
  logic [7:0]    od_d;

  // mode follows the pins only while idle
  assign mode = (state_q == IDLE) ?
                {mii_select, rmii_select} : mode_q;
  assign rmii = (mode == 2'b11);
  assign mii  = (mode == 2'b10);

  always_comb begin
    sh       = rxd;
    shc      = rxd;
    is_p     = 1'b0;
    last_cnt = 2'd0;
    unique case (1'b1)
      rmii: begin
        sh       = {rxd[1:0], w_q[7:2]};
        shc      = {rxd[1:0], 6'd0};
        is_p     = (rxd[1:0] == 2'b01);
        last_cnt = 2'd3;
      end
      mii: begin
        sh       = {rxd[3:0], w_q[7:4]};
        shc      = {rxd[3:0], 4'd0};
        is_p     = (rxd[3:0] == 4'h5);
        last_cnt = 2'd1;
      end
      default: begin
        sh       = rxd;
        shc      = rxd;
        is_p     = (rxd == 8'h55);
        last_cnt = 2'd0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    first_d  = first_q;
    err_d    = err_q;
    ov_d     = 1'b0;
    od_d     = 8'd0;
    os_d     = 1'b0;
    oe_d     = 1'b0;
    oerr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if (!rx_er && is_p) begin
            w_d     = shc;
            state_d = PREAMBLE;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_er) begin
          state_d = DROP;
        end else begin
          w_d = sh;
          if (sh == 8'hD5) begin
            state_d  = DATA;
            cnt_d    = 2'd0;
            err_d    = 1'b0;
            len_d    = '0;
            first_d  = 1'b1;
            hold_v_d = 1'b0;
          end else if (!is_p) begin
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (rx_dv) begin
          w_d = sh;
          if (rx_er) err_d = 1'b1;
          if (cnt_q == last_cnt) begin
            cnt_d = 2'd0;
            len_d = len_q + 1'b1;
            // the byte just completed would exceed the limit
            if (len_q == LW'(MAX_FRAME_LEN)) begin
              ov_d     = hold_v_q;
              od_d     = hold_q;
              os_d     = hold_v_q & first_q;
              oe_d     = hold_v_q;
              oerr_d   = hold_v_q;
              hold_v_d = 1'b0;
              state_d  = DROP;
            end else begin
              if (hold_v_q) begin
                ov_d    = 1'b1;
                od_d    = hold_q;
                os_d    = first_q;
                first_d = 1'b0;
              end
              hold_d   = sh;
              hold_v_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          if (hold_v_q) begin
            ov_d   = 1'b1;
            od_d   = hold_q;
            os_d   = first_q;
            oe_d   = 1'b1;
            oerr_d = err_q | rx_er | (cnt_q != 2'd0);
          end
          hold_v_d = 1'b0;
          state_d  = IDLE;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      w_q       <= 8'd0;
      cnt_q     <= 2'd0;
      len_q     <= '0;
      hold_q    <= 8'd0;
      hold_v_q  <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      first_q   <= first_d;
      err_q     <= err_d;
      out_valid <= ov_d;
      out_data  <= od_d;
      out_sof   <= os_d;
      out_eof   <= oe_d;
      out_err   <= oerr_d;
    end
  end

endmodule

// File: tb/tb_enet_rx_align.sv
// tb_enet_rx_align: frame-level model drives two aligners (default and
// 16-byte limit) and checks every output cycle against expected emissions.
module tb_enet_rx_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mii_select = 1'b0;
  logic       rmii_select = 1'b0;
  logic [7:0] rxd = 8'd0;
  logic       rx_dv = 1'b0;
  logic       rx_er = 1'b0;

  logic       ov0, os0, oe0, oer0;
  logic [7:0] od0;
  logic       ov1, os1, oe1, oer1;
  logic [7:0] od1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int now = 0;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       q[2][$];
  int         np[2];
  logic [7:0] lastd[2];
  logic [7:0] firstd[2];
  logic       lsof[2];
  logic       leof[2];
  logic       lerr[2];
  logic [7:0] fix[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enet_rx_align dut0 (
    .clk(clk), .rst_n(rst_n),
    .mii_select(mii_select), .rmii_select(rmii_select),
    .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_valid(ov0), .out_data(od0), .out_sof(os0),
    .out_eof(oe0), .out_err(oer0)
  );

  enet_rx_align #(.MAX_FRAME_LEN(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .mii_select(mii_select), .rmii_select(rmii_select),
    .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_valid(ov1), .out_data(od1), .out_sof(os1),
    .out_eof(oe1), .out_err(oer1)
  );

  task automatic ck(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cmp(input int w, input logic v, input logic [7:0] d,
                     input logic s, input logic e, input logic r);
    exp_t x;
    bit   have;
    have = 0;
    while (q[w].size() > 0 && q[w][0].cyc < cyc) begin
      x = q[w].pop_front();
      total++;
      bad++;
      $display("FAIL dut%0d missed byte %02h due cyc %0d", w, x.d, x.cyc);
    end
    if (q[w].size() > 0 && q[w][0].cyc == cyc) begin
      x = q[w].pop_front();
      have = 1;
    end
    total++;
    if (have) begin
      if (v !== 1'b1 || d !== x.d || s !== x.sof ||
          e !== x.eof || r !== x.err) begin
        bad++;
        $display("FAIL dut%0d byte cyc %0d: got v=%b d=%02h sof=%b eof=%b err=%b want d=%02h sof=%b eof=%b err=%b",
                 w, cyc, v, d, s, e, r, x.d, x.sof, x.eof, x.err);
      end
    end else if ({v, s, e, r} !== 4'b0000) begin
      bad++;
      $display("FAIL dut%0d idle cyc %0d: got v=%b d=%02h sof=%b eof=%b err=%b want none",
               w, cyc, v, d, s, e, r);
    end
    if (v === 1'b1) begin
      np[w]++;
      lastd[w] = d;
      lsof[w] = s;
      leof[w] = e;
      lerr[w] = r;
      if (s) firstd[w] = d;
    end
  endtask

  always @(negedge clk) begin
    cmp(0, ov0, od0, os0, oe0, oer0);
    cmp(1, ov1, od1, os1, oe1, oer1);
  end

  task automatic step(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_dv = dv;
    rx_er = er;
    rxd = d;
    now = cyc;
  endtask

  // modes: 0 RMII, 1 MII, 2 GMII, 3 RGMII
  function automatic int upb_of(input int m);
    return (m == 0) ? 4 : (m == 1) ? 2 : 1;
  endfunction

  function automatic logic [7:0] pre_of(input int m);
    return (m == 0) ? 8'h01 : (m == 1) ? 8'h05 : 8'h55;
  endfunction

  function automatic logic [7:0] sfd_of(input int m);
    return (m == 0) ? 8'h03 : (m == 1) ? 8'h0D : 8'hD5;
  endfunction

  function automatic logic [7:0] bad_of(input int m);
    return (m == 0) ? 8'h00 : (m == 1) ? 8'h07 : 8'h12;
  endfunction

  function automatic logic [1:0] pins_of(input int m);
    return (m == 0) ? 2'b11 : (m == 1) ? 2'b10 :
           (m == 2) ? 2'b00 : 2'b01;
  endfunction

  // Frame-level expectation: byte i leaves one cycle after byte i+1
  // completes; the last leaves one cycle after rx_dv drops; overflow
  // truncates at max with eof+err.
  task automatic model(input int w, input int max, input int c0,
                       input int npre, input int upb,
                       input logic [7:0] b[$], input int len,
                       input bit er_d, input int drib);
    exp_t x;
    int   s;
    int   t;
    int   nb;
    s = c0 + npre + 1;
    t = c0 + len;
    nb = b.size();
    if (nb > max) begin
      for (int i = 0; i < max; i++) begin
        x.d = b[i];
        x.sof = (i == 0);
        x.eof = (i == max - 1);
        x.err = (i == max - 1);
        x.cyc = s + (i + 2) * upb;
        q[w].push_back(x);
      end
    end else if (nb > 0) begin
      for (int i = 0; i < nb - 1; i++) begin
        x.d = b[i];
        x.sof = (i == 0);
        x.eof = 0;
        x.err = 0;
        x.cyc = s + (i + 2) * upb;
        q[w].push_back(x);
      end
      x.d = b[nb-1];
      x.sof = (nb == 1);
      x.eof = 1;
      x.err = er_d || (drib != 0);
      x.cyc = t + 1;
      q[w].push_back(x);
    end
  endtask

  task automatic do_abort();
    int   c_r;
    exp_t keep[$];
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_dv = 1'b1;
    rx_er = 1'b0;
    rxd = 8'hA3;
    c_r = cyc;
    for (int w = 0; w < 2; w++) begin
      keep.delete();
      for (int i = 0; i < q[w].size(); i++)
        if (q[w][i].cyc < c_r) keep.push_back(q[w][i]);
      q[w] = keep;
    end
    #1;
    ck("rst_valid0", int'(ov0), 0);
    ck("rst_valid1", int'(ov1), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1, 0, 8'hA3);
    repeat (3) step(0, 0, 8'h00);
  endtask

  task automatic send_frame(input int m, input int npre, input int nb,
                            input int drib, input int er_at,
                            input int bad_at, input int abort_at,
                            input bit chg, input int gap);
    logic [7:0] u[$];
    logic [7:0] b[$];
    logic [7:0] mk8;
    int         upb;
    int         uw;
    int         mk;
    int         len;
    bit         ok;
    upb = upb_of(m);
    uw = 8 / upb;
    mk = (1 << uw) - 1;
    mk8 = 8'(mk);
    for (int j = 0; j < npre; j++) u.push_back(pre_of(m));
    u.push_back(sfd_of(m));
    for (int i = 0; i < nb; i++)
      b.push_back((i < fix.size()) ? fix[i] : 8'($urandom));
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < upb; k++)
        u.push_back(8'((int'(b[i]) >> (k * uw)) & mk));
    for (int k = 0; k < drib; k++) u.push_back(8'($urandom) & mk8);
    if (bad_at >= 0) u[bad_at] = bad_of(m);
    len = u.size();
    ok = (bad_at < 0) && !(er_at >= 0 && er_at <= npre);
    {mii_select, rmii_select} = pins_of(m);
    for (int j = 0; j < len; j++) begin
      if (j == abort_at) begin
        do_abort();
        return;
      end
      step(1, (er_at == j), u[j] | (8'($urandom) & ~mk8));
      if (j == 0 && ok) begin
        model(0, 1522, now, npre, upb, b, len,
              (er_at > npre && er_at < len), drib);
        model(1, 16, now, npre, upb, b, len,
              (er_at > npre && er_at < len), drib);
      end
      if (chg && j == 1) {mii_select, rmii_select} = 2'($urandom);
    end
    for (int g = 0; g < gap; g++) step(0, 0, 8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int p0;
    int p1;
    int m;
    int npre;
    int nb;
    int drib;
    int er_at;
    int bad_at;
    int upb;
    np[0] = 0;
    np[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    ck("reset_valid0", int'(ov0), 0);
    ck("reset_data0", int'(od0), 0);
    ck("reset_valid1", int'(ov1), 0);
    rst_n = 1'b1;
    repeat (2) step(0, 0, 8'h00);

    // MII: 01 02 03
    fix = '{8'h01, 8'h02, 8'h03};
    p0 = np[0];
    send_frame(1, 15, 3, 0, -1, -1, -1, 0, 3);
    ck("mii_count", np[0] - p0, 3);
    ck("mii_first", int'(firstd[0]), 8'h01);
    ck("mii_last", int'(lastd[0]), 8'h03);
    ck("mii_eof", int'(leof[0]), 1);
    ck("mii_err", int'(lerr[0]), 0);

    // RMII single byte
    fix = '{8'hA5};
    p0 = np[0];
    send_frame(0, 31, 1, 0, -1, -1, -1, 0, 3);
    ck("rmii_count", np[0] - p0, 1);
    ck("rmii_data", int'(lastd[0]), 8'hA5);
    ck("rmii_sofeof", int'({lsof[0], leof[0], lerr[0]}), 3'b110);

    // GMII 64 bytes with rx_er on byte 10
    fix.delete();
    for (int i = 0; i < 64; i++) fix.push_back(8'(i));
    p0 = np[0];
    p1 = np[1];
    send_frame(2, 7, 64, 0, 18, -1, -1, 0, 3);
    ck("gmii_count", np[0] - p0, 64);
    ck("gmii_last", int'(lastd[0]), 8'h3F);
    ck("gmii_eoferr", int'({leof[0], lerr[0]}), 2'b11);
    ck("max16_count", np[1] - p1, 16);
    ck("max16_last", int'(lastd[1]), 8'h0F);
    ck("max16_eoferr", int'({leof[1], lerr[1]}), 2'b11);

    fix = '{8'hAA, 8'hBB};
    p1 = np[1];
    send_frame(2, 7, 2, 0, -1, -1, -1, 0, 3);
    ck("max16_next_count", np[1] - p1, 2);
    ck("max16_next_last", int'(lastd[1]), 8'hBB);
    ck("max16_next_err", int'(lerr[1]), 0);

    // MII dribble nibble
    fix.delete();
    p0 = np[0];
    send_frame(1, 15, 2, 1, -1, -1, -1, 0, 3);
    ck("dribble_count", np[0] - p0, 2);
    ck("dribble_eoferr", int'({leof[0], lerr[0]}), 2'b11);

    // MII preamble starting with nibble 7
    p0 = np[0];
    send_frame(1, 15, 3, 0, -1, 0, -1, 0, 3);
    ck("badpre_count", np[0] - p0, 0);

    // mode pins toggled mid-frame
    p0 = np[0];
    send_frame(1, 15, 4, 0, -1, -1, -1, 1, 3);
    ck("modechg_count", np[0] - p0, 4);

    // reset mid-payload, then garbage with rx_dv high
    p0 = np[0];
    send_frame(2, 7, 10, 0, -1, -1, 13, 0, 3);
    ck("abort_count", np[0] - p0, 3);
    fix = '{8'h11, 8'h22, 8'h33};
    p0 = np[0];
    send_frame(2, 7, 3, 0, -1, -1, -1, 0, 3);
    ck("post_rst_count", np[0] - p0, 3);
    ck("post_rst_first", int'(firstd[0]), 8'h11);
    ck("post_rst_last", int'(lastd[0]), 8'h33);
    fix.delete();

    repeat (150) begin
      m = $urandom_range(0, 3);
      upb = upb_of(m);
      npre = (m == 0) ? $urandom_range(3, 20) : $urandom_range(1, 10);
      nb = $urandom_range(0, 30);
      drib = ($urandom_range(0, 3) == 0) ? $urandom_range(0, upb - 1) : 0;
      er_at = ($urandom_range(0, 7) == 0) ?
              $urandom_range(0, npre + nb * upb + drib) : -1;
      bad_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, npre - 1) : -1;
      send_frame(m, npre, nb, drib, er_at, bad_at, -1,
                 ($urandom_range(0, 3) == 0), $urandom_range(3, 6));
    end

    repeat (5) step(0, 0, 8'h00);
    ck("queue0_empty", q[0].size(), 0);
    ck("queue1_empty", q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
